dmem_mp: RTL and testbench

//  Parametrised data-memory array for the OoO load/store path: one byte-masked write port and
//  NRD independent read ports, all on one clock, with a configurable read pipeline.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_rd_pipe.sv | 36 +++
 rtl/dmem_mp.sv | 83 ++++++++
 tb/tb_dmem_mp.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the multi-port data memory: lane count derivation,
// byte-mask merge and the same-cycle collision mode encoding.
package dmem_pkg;

  localparam int MAX_DW = 256;
  localparam int MAX_NB = MAX_DW / 8;

  localparam bit WR_NEW_FIRST = 1'b1;
  localparam bit WR_OLD_FIRST = 1'b0;

  function automatic int nbyte_of(input int dw);
    return dw / 8;
  endfunction

  // Callers zero-extend to MAX_DW and truncate the result back to their own width.
  function automatic logic [MAX_DW-1:0] merge_bytes(input logic [MAX_DW-1:0] old_w,
                                                    input logic [MAX_DW-1:0] new_w,
                                                    input logic [MAX_NB-1:0] mask);
    logic [MAX_DW-1:0] res;
    res = old_w;
    for (int i = 0; i < MAX_NB; i++) begin
      if (mask[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_rd_pipe.sv
// Read-latency pipe for one load port: the snapshot enters stage 0 on the sample
// edge and reaches the output register READ_LAT-1 edges later.
module dmem_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int READ_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [READ_LAT-1:0]   vld_reg;
  logic [DATA_WIDTH-1:0] dat_reg [0:READ_LAT-1];

  // Data stages only load behind a valid, so the last stage holds its value between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_reg <= '0;
      for (int i = 0; i < READ_LAT; i++) dat_reg[i] <= '0;
    end else begin
      vld_reg[0] <= in_valid;
      if (in_valid) dat_reg[0] <= in_data;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_reg[i] <= vld_reg[i-1];
        if (vld_reg[i-1]) dat_reg[i] <= dat_reg[i-1];
      end
    end
  end

  assign out_valid = vld_reg[READ_LAT-1];
  assign out_data  = dat_reg[READ_LAT-1];

endmodule

// File: rtl/dmem_mp.sv
// Data memory with one byte-masked store port and NRD load ports, selectable
// read/write collision behaviour and a saturating collision counter.
module dmem_mp
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int NRD        = 2,
  parameter int READ_LAT   = 1,
  parameter bit WR_FIRST   = WR_NEW_FIRST
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      csb0,
  input  logic [DATA_WIDTH/8-1:0]   wmask0,
  input  logic [ADDR_WIDTH-1:0]     addr0,
  input  logic [DATA_WIDTH-1:0]     din0,
  input  logic [NRD-1:0]            csb1,
  input  logic [NRD*ADDR_WIDTH-1:0] addr1,
  output logic [NRD*DATA_WIDTH-1:0] dout1,
  output logic [NRD-1:0]            rvalid1,
  output logic [15:0]               coll_cnt
);

  localparam int NBYTE     = nbyte_of(DATA_WIDTH);
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_reg [0:RAM_DEPTH-1];
  logic [NBYTE-1:0]      lane_en;
  logic                  wr_act;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [NRD-1:0]        hit_vec;
  logic [2:0]            hit_cnt;
  logic [16:0]           coll_sum;
  logic [15:0]           coll_cnt_reg, coll_cnt_next;

  assign lane_en = wmask0;
  assign wr_act  = !csb0 && (|lane_en);
  assign wr_word = DATA_WIDTH'(merge_bytes(MAX_DW'(mem_reg[addr0]), MAX_DW'(din0),
                                           MAX_NB'(lane_en)));

  // Array contents survive reset; a write is simply suppressed while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n && wr_act) mem_reg[addr0] <= wr_word;
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] snap;

    assign rd_addr     = addr1[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign hit_vec[gi] = wr_act && !csb1[gi] && (rd_addr == addr0);
    // On a hit the merged store word is exactly what the array will hold after this edge.
    assign snap = (WR_FIRST == WR_NEW_FIRST && hit_vec[gi]) ? wr_word : mem_reg[rd_addr];

    dmem_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .READ_LAT   (READ_LAT)
    ) u_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (!csb1[gi]),
      .in_data   (snap),
      .out_valid (rvalid1[gi]),
      .out_data  (dout1[gi*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < NRD; i++) hit_cnt = hit_cnt + 3'(hit_vec[i]);
    coll_sum      = {1'b0, coll_cnt_reg} + 17'(hit_cnt);
    coll_cnt_next = coll_sum[16] ? 16'hFFFF : coll_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coll_cnt_reg <= '0;
    else        coll_cnt_reg <= coll_cnt_next;
  end

  assign coll_cnt = coll_cnt_reg;

endmodule

// File: tb/tb_dmem_mp.sv
// Randomised and directed bench for dmem_mp against a behavioural memory model.
module tb_dmem_mp;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int NRD = 2;
  localparam int RL = 3;
  localparam bit WF = 1'b1;
  localparam int NB = DW / 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              csb0 = 1'b1;
  logic [NB-1:0]     wmask0 = '0;
  logic [AW-1:0]     addr0 = '0;
  logic [DW-1:0]     din0 = '0;
  logic [NRD-1:0]    csb1 = '1;
  logic [NRD*AW-1:0] addr1 = '0;
  logic [NRD*DW-1:0] dout1;
  logic [NRD-1:0]    rvalid1;
  logic [15:0]       coll_cnt;

  always #5 clk = ~clk;

  dmem_mp #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NRD        (NRD),
    .READ_LAT   (RL),
    .WR_FIRST   (WF)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .csb0     (csb0),
    .wmask0   (wmask0),
    .addr0    (addr0),
    .din0     (din0),
    .csb1     (csb1),
    .addr1    (addr1),
    .dout1    (dout1),
    .rvalid1  (rvalid1),
    .coll_cnt (coll_cnt)
  );

  typedef struct {
    int          port;
    int          due;
    logic [DW-1:0] data;
  } rd_t;

  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  rd_t           pend [$];
  logic [DW-1:0] exp_dout [NRD];
  int            strobes [NRD];
  int            ref_coll = 0;
  int            edge_n = 0;
  int            checks = 0;
  int            failures = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] wr_apply(input logic [DW-1:0] old_w);
    logic [DW-1:0] r;
    r = old_w;
    for (int l = 0; l < NB; l++) if (wmask0[l]) r[l*8 +: 8] = din0[l*8 +: 8];
    return r;
  endfunction

  task automatic idle();
    csb0 = 1'b1; wmask0 = '0; csb1 = '1;
  endtask

  task automatic set_wr(input logic [AW-1:0] a, input logic [NB-1:0] m, input logic [DW-1:0] d);
    csb0 = 1'b0; addr0 = a; wmask0 = m; din0 = d;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    csb1[p] = 1'b0; addr1[p*AW +: AW] = a;
  endtask

  // One clock: model the sample edge, advance, then compare every port and the counter.
  task automatic tick();
    logic [AW-1:0] a;
    logic [DW-1:0] w;
    bit hit, exp_v;
    int idx;
    for (int p = 0; p < NRD; p++) begin
      if (!csb1[p]) begin
        a = addr1[p*AW +: AW];
        w = ref_mem[a];
        hit = !csb0 && (wmask0 != '0) && (a == addr0);
        if (hit) begin
          if (ref_coll < 65535) ref_coll++;
          if (WF) w = wr_apply(w);
        end
        pend.push_back('{p, edge_n + RL, w});
      end
    end
    if (!csb0) ref_mem[addr0] = wr_apply(ref_mem[addr0]);
    @(posedge clk);
    edge_n++;
    #1;
    for (int p = 0; p < NRD; p++) begin
      exp_v = 1'b0;
      idx = -1;
      foreach (pend[i]) if (pend[i].port == p && pend[i].due == edge_n) idx = i;
      if (idx >= 0) begin
        exp_v = 1'b1;
        exp_dout[p] = pend[idx].data;
        pend.delete(idx);
      end
      if (rvalid1[p]) strobes[p]++;
      check_val($sformatf("rvalid%0d@%0d", p, edge_n), 64'(rvalid1[p]), 64'(exp_v));
      check_val($sformatf("dout%0d@%0d", p, edge_n), 64'(dout1[p*DW +: DW]), 64'(exp_dout[p]));
    end
    check_val($sformatf("coll_cnt@%0d", edge_n), 64'(coll_cnt), 64'(ref_coll));
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    pend.delete();
    for (int p = 0; p < NRD; p++) exp_dout[p] = '0;
    ref_coll = 0;
    #1;
    check_val("rst_async_dout", 64'(dout1), 64'd0);
    repeat (n) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
    check_val("rst_dout", 64'(dout1), 64'd0);
    check_val("rst_rvalid", 64'(rvalid1), 64'd0);
    check_val("rst_coll", 64'(coll_cnt), 64'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int p = 0; p < NRD; p++) begin exp_dout[p] = '0; strobes[p] = 0; end
    apply_reset(2);

    for (int i = 0; i < (1 << AW); i++) begin
      idle(); set_wr(AW'(i), '1, $urandom); tick();
    end
    idle(); tick();

    // Full-word write then read on port 0
    idle(); set_wr(5, 4'hF, 32'hDEADBEEF); tick();
    idle(); set_rd(0, 5); tick();
    idle(); repeat (RL - 1) tick();
    check_val("t1_dout", 64'(dout1[0 +: DW]), 64'h0000_0000_DEAD_BEEF);
    check_val("t1_rvalid", 64'(rvalid1[0]), 64'd1);
    tick();
    check_val("t1_rvalid_drop", 64'(rvalid1[0]), 64'd0);

    // Partial write
    idle(); set_wr(7, 4'hF, 32'hAABBCCDD); tick();
    idle(); set_wr(7, 4'b0101, 32'h11223344); tick();
    idle(); set_rd(0, 7); tick();
    idle(); repeat (RL - 1) tick();
    check_val("t2_dout", 64'(dout1[0 +: DW]), 64'h0000_0000_AA22_CC44);

    // Same-cycle collision on port 1
    idle(); set_wr(9, 4'hF, 32'h0); tick();
    check_val("t3_coll_before", 64'(coll_cnt), 64'd0);
    idle(); set_wr(9, 4'hF, 32'h5A5A5A5A); set_rd(1, 9); tick();
    check_val("t3_coll_after", 64'(coll_cnt), 64'd1);
    idle(); repeat (RL - 1) tick();
    check_val("t3_dout", 64'(dout1[DW +: DW]), WF ? 64'h5A5A5A5A : 64'd0);

    // Masked-off write with matching read: no collision
    idle(); set_wr(9, 4'h0, 32'hFFFFFFFF); set_rd(0, 9); tick();
    check_val("t3_nomask_coll", 64'(coll_cnt), 64'd1);
    idle(); repeat (RL + 1) tick();

    // Streaming reads on both ports
    for (int p = 0; p < NRD; p++) strobes[p] = 0;
    for (int i = 0; i < 16; i++) begin
      idle(); set_rd(0, AW'(i)); set_rd(1, AW'(i)); tick();
    end
    idle(); repeat (RL + 1) tick();
    check_val("t4_strobes0", 64'(strobes[0]), 64'd16);
    check_val("t4_strobes1", 64'(strobes[1]), 64'd16);

    // Random traffic away from the directed addresses
    for (int n = 0; n < 400; n++) begin
      idle();
      if ($urandom_range(1, 0) == 1)
        set_wr(AW'($urandom_range(31, 16)), NB'($urandom), $urandom);
      for (int p = 0; p < NRD; p++)
        if ($urandom_range(1, 0) == 1) set_rd(p, AW'($urandom_range(31, 16)));
      tick();
    end
    idle(); repeat (RL + 1) tick();

    // Reset with a read in flight and a write pending
    idle(); set_rd(0, 5); tick();
    idle(); tick();
    set_wr(5, 4'hF, 32'h0BADF00D);
    apply_reset(3);
    for (int p = 0; p < NRD; p++) strobes[p] = 0;
    idle(); repeat (RL + 2) tick();
    check_val("t5_no_strobe", 64'(strobes[0]), 64'd0);
    idle(); set_rd(0, 5); tick();
    idle(); repeat (RL - 1) tick();
    check_val("t5_readback", 64'(dout1[0 +: DW]), 64'h0000_0000_DEAD_BEEF);

    // Counter saturation: two collisions per cycle
    for (int n = 0; n < 35000; n++) begin
      idle(); set_wr(3, 4'hF, $urandom); set_rd(0, 3); set_rd(1, 3); tick();
    end
    check_val("t6_sat", 64'(coll_cnt), 64'h0000_0000_0000_FFFF);
    idle(); repeat (RL + 1) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
